// File: rtl/seqcompare_st_if.sv
`default_nettype none
// ============================================================================
//  Module      : seqcompare_st_if
//  Description : Request/result bundle of the sequential magnitude comparator.
//                The requester drives start and the operands; the comparator
//                returns busy, the done pulse and the one-hot ordering flags.
//  Revision    : 1.0 - initial release
// ============================================================================
interface seqcompare_st_if #(
   parameter int NBITS = 32
) ();
   logic             start;
   logic [NBITS-1:0] a;
   logic [NBITS-1:0] b;
   logic             busy;
   logic             done;
   logic             eq;
   logic             lt;
   logic             gt;

   modport master (
      output start, a, b,
      input  busy, done, eq, lt, gt
   );

   modport slave (
      input  start, a, b,
      output busy, done, eq, lt, gt
   );
endinterface
`default_nettype wire

// File: rtl/seqcompare_st.sv
`default_nettype none
// ============================================================================
//  Module      : seqcompare_st
//  Description : Multi-cycle magnitude comparator. Captures A and B on start,
//                resolves A + ~B + 1 CHUNK bits per clock (LSB first) through a
//                ripple full-adder chain and reports one-hot eq/lt/gt with a
//                one-cycle done pulse after NBITS/CHUNK cycles.
//                Optional macro SEQCOMPARE_SIGNED_EN: two's-complement ordering
//                (sign ^ overflow of the final chunk); default is unsigned.
//  Revision    : 1.0 - initial release
// ============================================================================
module seqcompare_st #(
   parameter int NBITS = 32,
   parameter int CHUNK = 4
) (
   input  wire              clk,
   input  wire              rst_n,
   seqcompare_st_if.slave   bus
);

   localparam int N  = NBITS / CHUNK;
   localparam int CW = $clog2(N) + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [NBITS-1:0] a_q;
   logic [NBITS-1:0] b_q;
   logic [CW-1:0]    cnt_q;
   logic             carry_q;
   logic             eq_acc_q;
   logic             busy_q;
   logic             done_q;
   logic             eq_q;
   logic             lt_q;
   logic             gt_q;

   // Ripple chain for the current chunk: c_d[0] is the carry held from the
   // previous chunk (1 on the first chunk, completing the +1 of negation).
   logic [CHUNK:0]   c_d;
   logic             eq_acc_d;
   logic             lt_d;

   assign c_d[0] = carry_q;

   for (genvar i = 0; i < CHUNK; i++) begin : g_fa
      logic nb_d;
      assign nb_d     = ~b_q[i];
      assign c_d[i+1] = (a_q[i] & nb_d) | (a_q[i] & c_d[i]) | (nb_d & c_d[i]);
   end

   assign eq_acc_d = eq_acc_q & (a_q[CHUNK-1:0] == b_q[CHUNK-1:0]);

`ifdef SEQCOMPARE_SIGNED_EN
   // On the last chunk the top adder bit is the operand MSB: A < B exactly
   // when the sign of A - B disagrees with the overflow indication.
   logic sum_msb_d;
   logic ovf_d;
   assign sum_msb_d = a_q[CHUNK-1] ^ ~b_q[CHUNK-1] ^ c_d[CHUNK-1];
   assign ovf_d     = c_d[CHUNK-1] ^ c_d[CHUNK];
   assign lt_d      = sum_msb_d ^ ovf_d;
`else
   // Unsigned: no carry out of A + ~B + 1 means a borrow, i.e. A < B.
   assign lt_d = ~c_d[CHUNK];
`endif

   // Control FSM, operand shifters and registered result flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         eq_acc_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         eq_q     <= 1'b0;
         lt_q     <= 1'b0;
         gt_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  a_q      <= bus.a;
                  b_q      <= bus.b;
                  carry_q  <= 1'b1;
                  eq_acc_q <= 1'b1;
                  cnt_q    <= CW'(N);
                  busy_q   <= 1'b1;
                  state_q  <= S_RUN;
               end else begin
                  state_q  <= S_IDLE;
               end
            end
            S_RUN: begin
               carry_q  <= c_d[CHUNK];
               eq_acc_q <= eq_acc_d;
               a_q      <= a_q >> CHUNK;
               b_q      <= b_q >> CHUNK;
               cnt_q    <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  eq_q    <= eq_acc_d;
                  lt_q    <= lt_d;
                  gt_q    <= ~eq_acc_d & ~lt_d;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.eq   = eq_q;
   assign bus.lt   = lt_q;
   assign bus.gt   = gt_q;

endmodule
`default_nettype wire
